// File: rtl/cpu_pkg.sv
// Shared front-end constants: datapath width and the NOP used
// when no instruction is available.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with synchronous clear and
// a combinational head view.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign head_valid = (count != '0);
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request credit and stale-response dropping.
// Optional MISALIGN_CHECK_EN adds fetch_misaligned.
module instr_fetch #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef MISALIGN_CHECK_EN
  output logic            fetch_misaligned,
`endif
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] next_pc_out
);
  import cpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = XLEN + INSTR_W;

  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] drop_cnt, fifo_count, credit_used;
  logic req_fire, resp_acc, push, pop;
  logic misaligned;
  logic [EW-1:0] head;
  logic head_valid;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else if (redirect) misaligned <= (redirect_pc[1:0] != 2'b00);
  end
  assign fetch_misaligned = misaligned;
`else
  assign misaligned = 1'b0;
`endif

  // A pop this edge frees a slot, so it counts toward the credit now.
  assign pop = head_valid && instr_ready;
  assign credit_used = outstanding + fifo_count - CW'(pop);
  assign imem_req_valid = !rst && !redirect && !misaligned
                       && (credit_used < CW'(FIFO_DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign resp_acc = imem_resp_valid
                 && ((outstanding != '0) || req_fire);
  assign outstanding_n = outstanding + CW'(req_fire) - CW'(resp_acc);
  assign push = resp_acc && (drop_cnt == '0) && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding_n;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) resp_pc <= resp_pc + XLEN'(4);
        if (resp_acc && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W(EW)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(redirect),
    .push(push),
    .push_data({resp_pc, imem_resp_data}),
    .pop(pop),
    .head(head),
    .head_valid(head_valid),
    .count(fifo_count)
  );

  assign instr_valid = head_valid;
  assign instr = head_valid ? head[INSTR_W-1:0] : NOP_INSTR;
  assign pc_out = head_valid ? head[EW-1:INSTR_W] : resp_pc;
  assign next_pc_out = pc_out + XLEN'(4);
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a stream-level model.
// Build with MISALIGN_CHECK_EN to cover fetch_misaligned.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst, redirect;
  logic [31:0] redirect_pc;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic instr_valid, instr_ready;
  logic [31:0] instr, pc_out, next_pc_out;
`ifdef MISALIGN_CHECK_EN
  logic fetch_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .XLEN(32),
    .RESET_PC(RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
`ifdef MISALIGN_CHECK_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .pc_out(pc_out),
    .next_pc_out(next_pc_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int due;
  } pend_t;
  pend_t q[$];

  int p_rdy = 100, p_irdy = 100, p_redir = 0;
  int lat_lo = 1, lat_hi = 1;
  bit force_redir = 0;
  logic [31:0] force_tgt;

  logic [31:0] exp_req, exp_head, first_pop;
  bit mis_m, want_first, seen_wrap;
  bit saw_combo;
  int cyc, last_due, fires, first_valid;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", pc_out, RPC);
    chk("rst_next_pc", next_pc_out, RPC + 4);
`ifdef MISALIGN_CHECK_EN
    chk("rst_misaligned", fetch_misaligned, 0);
`endif
    exp_req = RPC;
    exp_head = RPC;
    mis_m = 0;
    want_first = 0;
    cyc = 0;
    last_due = 0;
    fires = 0;
    first_valid = -1;
  endtask

  task automatic step();
    logic [31:0] t;
    int lat;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    instr_ready = ($urandom_range(99) < p_irdy);
    redirect = force_redir || ($urandom_range(999) < p_redir);
    if (force_redir) begin
      redirect_pc = force_tgt;
    end else begin
      case ($urandom_range(2))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(15));
        default: redirect_pc = 32'($urandom_range(1023));
      endcase
      if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
    end
    force_redir = 0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = mem_word(q[0].addr);
      void'(q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    @(negedge clk);
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (redirect && imem_resp_valid && instr_valid && instr_ready)
      saw_combo = 1;
`ifdef MISALIGN_CHECK_EN
    chk("misaligned_flag", fetch_misaligned, mis_m);
`endif
    if (mis_m) chk("misal_idle", {instr_valid, imem_req_valid}, 0);
    if (!instr_valid) chk("empty_nop", instr, NOP);
    if (instr_valid && instr_ready) begin
      chk("head_pc", pc_out, exp_head);
      chk("head_instr", instr, mem_word(exp_head));
      chk("head_next_pc", next_pc_out, exp_head + 4);
      if (exp_head == 32'hFFFFFFFC) seen_wrap = 1;
      if (want_first) begin
        first_pop = pc_out;
        want_first = 0;
      end
      exp_head = exp_head + 4;
    end
    if (redirect) chk("req_in_redirect", imem_req_valid, 0);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, exp_req);
      if (imem_req_ready) begin
        lat = $urandom_range(lat_hi, lat_lo);
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        q.push_back('{addr: imem_req_addr, due: last_due});
        exp_req = exp_req + 4;
        fires++;
      end
    end
    chk("inflight_cap", q.size() <= DEPTH, 1);
    if (redirect) begin
      t = {redirect_pc[31:2], 2'b00};
      exp_req = t;
      exp_head = t;
      want_first = 1;
`ifdef MISALIGN_CHECK_EN
      mis_m = (redirect_pc[1:0] != 2'b00);
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    saw_combo = 0;
    seen_wrap = 0;
    first_pop = '0;

    // Streaming start-up with 1-cycle memory.
    do_reset();
    p_rdy = 100; p_irdy = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
    run(4);
    chk("startup_fires", fires, 4);
    chk("startup_latency", first_valid, 3);
    run(6);

    // Decode stalled: credit limit.
    do_reset();
    p_irdy = 0;
    run(8);
    chk("stall_fires", fires, 2);
    chk("stall_req_low", imem_req_valid, 0);
    chk("stall_head_pc", pc_out, RPC);
    chk("stall_head_valid", instr_valid, 1);
    p_irdy = 100;
    run(1);
    p_irdy = 0;
    run(4);
    chk("stall_one_more", fires, 3);

    // Redirect with two slow requests in flight.
    do_reset();
    p_irdy = 0; lat_lo = 3; lat_hi = 3;
    run(2);
    chk("inflight_two", q.size(), 2);
    force_redir = 1; force_tgt = 32'h100;
    run(1);
    p_irdy = 100;
    run(14);
    chk("redir_first_pc", first_pop, 32'h100);

    // Redirect colliding with a response and a head handshake.
    do_reset();
    lat_lo = 1; lat_hi = 1; p_irdy = 100;
    run(5);
    force_redir = 1; force_tgt = 32'h400;
    run(1);
    chk("combo_seen", saw_combo, 1);
    run(10);
    chk("combo_first_pc", first_pop, 32'h400);

    // PC wrap at the top of the address space.
    do_reset();
    force_redir = 1; force_tgt = 32'hFFFFFFF8;
    run(12);
    chk("wrap_seen", seen_wrap, 1);

`ifdef MISALIGN_CHECK_EN
    do_reset();
    force_redir = 1; force_tgt = 32'h102;
    run(1);
    fires = 0;
    run(5);
    chk("misal_set", fetch_misaligned, 1);
    chk("misal_no_req", fires, 0);
    force_redir = 1; force_tgt = 32'h200;
    run(8);
    chk("misal_clear", fetch_misaligned, 0);
    chk("misal_resume_pc", first_pop, 32'h200);
`endif

    // Randomized traffic.
    do_reset();
    p_rdy = 70; p_irdy = 60; p_redir = 60; lat_lo = 1; lat_hi = 4;
    run(3000);
    p_redir = 0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end stage producing the instr/pc/next_pc stream consumed by instr_decode.
- Keeps the fetch PC and issues in-order requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h00000000, PC loaded on reset.
- FIFO_DEPTH, 2, buffered instruction entries; also the cap on outstanding requests plus buffered entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  execute resolved a taken branch or jump.
- redirect_pc  in  XLEN  new fetch target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word address (byte addressed, 4-aligned).
- imem_resp_valid  in  1  response word valid; responses arrive in request order, at most one per cycle.
- imem_resp_data  in  32  fetched instruction.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  32  head instruction; 32'h00000013 (NOP) when empty.
- pc_out  out  XLEN  head PC.
- next_pc_out  out  XLEN  pc_out + 4.

Behaviour:
- Reset:
  - fetch_pc and resp_pc load RESET_PC; the FIFO, outstanding counter and drop_cnt clear.
  - imem_req_valid=0, instr_valid=0, instr=NOP, pc_out=RESET_PC.
  - Reset mid-operation discards everything; responses to pre-reset requests are NOT tracked, so the memory must also be reset.
- Request issue:
  - imem_req_valid=1 when !rst && !redirect && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (mod 2^XLEN, wraps silently) and outstanding increments.
- Response:
  - On imem_resp_valid, outstanding decrements.
  - If drop_cnt>0: drop_cnt decrements and the word is discarded.
  - Otherwise push {resp_pc, data} into the FIFO and resp_pc += 4.
  - Overflow cannot occur because of the credit rule. An unexpected response with outstanding==0 is a protocol error and is ignored.
- Output:
  - Driven from the FIFO head; latency from response to instr_valid is 1 cycle.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (single-cycle pulse):
  - Same edge: fetch_pc and resp_pc load redirect_pc, the FIFO clears, and drop_cnt = outstanding after this cycle's request and response accounting.
  - A response arriving in the redirect cycle is dropped and does not count toward the new drop_cnt.
  - A head handshake in the redirect cycle counts as consumed; no re-presentation.
  - The first request to redirect_pc issues the next cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Throughput: with zero-latency, always-ready memory and ready decode, one instruction per cycle in steady state.

Optional Feature:
- MISALIGN_CHECK_EN
  - Defined: adds output port fetch_misaligned (1 bit).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 and still flushes. Requests are then suppressed until an aligned redirect (clears the flag) or rst.
  - Undefined: no port; redirect_pc[1:0] is treated as 2'b00.

Decomposition:
- Shared package (cpu_pkg): XLEN, NOP_INSTR = 32'h00000013, INSTR_W = 32.
- One sub-module: fetch_fifo.
  - Parameterised depth and width, synchronous clear, push/pop/count, head outputs.
  - instr_fetch owns the PC, credit, and drop logic.

Test Plan:
1. Reset with RESET_PC=0, always-ready memory with 1-cycle latency, ready decode. Require addresses 0,4,8,C in consecutive cycles, instr_valid rising 2 cycles after rst falls, pc_out/next_pc_out 0/4 then 4/8.
2. Hold instr_ready=0 with FIFO_DEPTH=2. Require exactly 2 requests issued, imem_req_valid then low, and the head holding pc_out=0 until ready; one pop yields one new request.
3. Memory with 3-cycle latency and 2 requests in flight, redirect to 0x100. Require both stale responses dropped, the next request addr=0x100, and the first instr_valid showing pc_out=0x100.
4. Redirect asserted in the same cycle as a response and a head handshake. Require that response dropped, drop_cnt = remaining outstanding, and no stale PC ever presented.
5. fetch_pc=32'hFFFFFFFC. Require the next request addr=0 and next_pc_out=0 for that entry.
6. With MISALIGN_CHECK_EN, redirect to 0x102. Require fetch_misaligned=1 and no requests; a redirect to 0x200 clears the flag and fetch resumes at 0x200.
